// File: rtl/spi_denetleyici_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_denetleyici_pkg
// Description : Shared constants, FSM encodings and TX queue entry layout.
// Revision    : 1.0
// ============================================================================
`ifndef SPI_TXN_SIZE
`define SPI_TXN_SIZE 8
`endif

package spi_denetleyici_pkg;

    localparam int c_W = `SPI_TXN_SIZE;

    localparam logic [1:0] c_ST_BOSTA   = 2'd0;
    localparam logic [1:0] c_ST_GONDER  = 2'd1;
    localparam logic [1:0] c_ST_BASLADI = 2'd2;
    localparam logic [1:0] c_ST_BEKLE   = 2'd3;

    localparam logic [1:0] c_DIR_OKU = 2'b01;

    typedef struct packed {
        logic [c_W-1:0] data;
        logic [1:0]     dir;
        logic           end_cs;
        logic           hint;
    } tx_kayit_t;

    localparam int c_TX_KAYIT_W = $bits(tx_kayit_t);

    // Only pure receive commands produce a word that needs an RX slot.
    function automatic logic rx_rezerve(input logic [1:0] dir);
        return dir == c_DIR_OKU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_kuyruk.sv
`default_nettype none
// ============================================================================
// Module      : spi_kuyruk
// Description : Parameterised synchronous FIFO with occupancy output.
// Revision    : 1.0
// ============================================================================
module spi_kuyruk #(
    parameter int GENISLIK = 8,
    parameter int DERINLIK = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic [GENISLIK-1:0]       push_data_i,
    input  logic                      pop_i,
    output logic [GENISLIK-1:0]       pop_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DERINLIK):0] doluluk_o
);

    localparam int c_PW = $clog2(DERINLIK);
    localparam logic [c_PW-1:0] c_PTR_BIR = 1;
    localparam logic [c_PW:0]   c_SAY_BIR = 1;
    localparam logic [c_PW:0]   c_DOLU    = DERINLIK[c_PW:0];

    logic [GENISLIK-1:0] r_mem [DERINLIK];
    logic [c_PW-1:0]     r_wr_ptr;
    logic [c_PW-1:0]     r_rd_ptr;
    logic [c_PW:0]       r_count;
    logic                w_push;
    logic                w_pop;

    assign empty_o    = (r_count == '0);
    assign full_o     = (r_count == c_DOLU);
    assign doluluk_o  = r_count;
    assign pop_data_o = r_mem[r_rd_ptr];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_BIR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_BIR;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_SAY_BIR;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_SAY_BIR;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_denetleyici.sv
`default_nettype none
// ============================================================================
// Module      : spi_denetleyici
// Description : Host-to-SPI command sequencer with TX command and RX data queues.
// Revision    : 1.0
// ============================================================================
module spi_denetleyici
    import spi_denetleyici_pkg::*;
#(
    parameter int KUYRUK_DERINLIK = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cfg_cpol_i,
    input  logic                             cfg_cpha_i,
    input  logic                             cfg_msb_first_i,
    input  logic [15:0]                      cfg_sck_div_i,
    input  logic                             host_cmd_valid_i,
    output logic                             host_cmd_ready_o,
    input  logic [c_W-1:0]                   host_cmd_data_i,
    input  logic [1:0]                       host_cmd_dir_i,
    input  logic                             host_cmd_end_cs_i,
    input  logic                             host_cmd_hint_i,
    output logic [c_W-1:0]                   rx_data_o,
    output logic                             rx_valid_o,
    input  logic                             rx_ready_i,
    output logic [c_W-1:0]                   spi_cmd_data_o,
    output logic [1:0]                       spi_cmd_dir_o,
    output logic                             spi_cmd_end_cs_o,
    output logic                             spi_cmd_hint_o,
    output logic                             spi_cmd_valid_o,
    output logic                             spi_cmd_cpol_o,
    output logic                             spi_cmd_cpha_o,
    output logic                             spi_cmd_msb_first_o,
    output logic [15:0]                      spi_cmd_sck_div_o,
    input  logic                             spi_cmd_ready_i,
    input  logic [c_W-1:0]                   spi_recv_data_i,
    input  logic                             spi_recv_valid_i,
    output logic [$clog2(KUYRUK_DERINLIK):0] tx_doluluk_o,
    output logic [$clog2(KUYRUK_DERINLIK):0] rx_doluluk_o,
    output logic                             busy_o
);

    localparam int c_DW = $clog2(KUYRUK_DERINLIK) + 1;
    localparam logic [c_DW-1:0] c_DERINLIK = KUYRUK_DERINLIK[c_DW-1:0];

    logic [1:0]              r_durum;
    logic                    r_cmd_valid;
    logic [c_W-1:0]          r_cmd_data;
    logic [1:0]              r_cmd_dir;
    logic                    r_cmd_end_cs;
    logic                    r_cmd_hint;
    logic                    r_okuma;

    tx_kayit_t               w_tx_yaz;
    tx_kayit_t               w_tx_bas;
    logic [c_TX_KAYIT_W-1:0] w_tx_bas_bits;
    logic                    w_tx_push;
    logic                    w_tx_pop;
    logic                    w_tx_dolu;
    logic                    w_tx_bos;
    logic                    w_rx_push;
    logic                    w_rx_pop;
    logic                    w_rx_dolu;
    logic                    w_rx_bos;
    logic [c_DW-1:0]         w_rx_toplam;
    logic                    w_rx_yer;
    logic                    w_basla;

    assign w_tx_yaz.data   = host_cmd_data_i;
    assign w_tx_yaz.dir    = host_cmd_dir_i;
    assign w_tx_yaz.end_cs = host_cmd_end_cs_i;
    assign w_tx_yaz.hint   = host_cmd_hint_i;
    assign w_tx_bas        = w_tx_bas_bits;

    assign host_cmd_ready_o = ~w_tx_dolu;
    assign w_tx_push        = host_cmd_valid_i & host_cmd_ready_o;
    assign w_tx_pop         = r_cmd_valid & spi_cmd_ready_i;

    spi_kuyruk #(
        .GENISLIK (c_TX_KAYIT_W),
        .DERINLIK (KUYRUK_DERINLIK)
    ) u_tx_kuyruk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_tx_push),
        .push_data_i (w_tx_yaz),
        .pop_i       (w_tx_pop),
        .pop_data_o  (w_tx_bas_bits),
        .full_o      (w_tx_dolu),
        .empty_o     (w_tx_bos),
        .doluluk_o   (tx_doluluk_o)
    );

    // Received words are only accepted while a read is actually in flight.
    assign w_rx_push  = (r_durum == c_ST_BEKLE) & r_okuma & spi_recv_valid_i;
    assign rx_valid_o = ~w_rx_bos;
    assign w_rx_pop   = rx_valid_o & rx_ready_i;

    spi_kuyruk #(
        .GENISLIK (c_W),
        .DERINLIK (KUYRUK_DERINLIK)
    ) u_rx_kuyruk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_rx_push),
        .push_data_i (spi_recv_data_i),
        .pop_i       (w_rx_pop),
        .pop_data_o  (rx_data_o),
        .full_o      (w_rx_dolu),
        .empty_o     (w_rx_bos),
        .doluluk_o   (rx_doluluk_o)
    );

    assign w_rx_toplam = rx_doluluk_o + {{(c_DW-1){1'b0}}, r_okuma};
    assign w_rx_yer    = ~w_rx_dolu & (w_rx_toplam < c_DERINLIK);
    assign w_basla     = ~w_tx_bos & (~rx_rezerve(w_tx_bas.dir) | w_rx_yer);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum      <= c_ST_BOSTA;
            r_cmd_valid  <= 1'b0;
            r_cmd_data   <= '0;
            r_cmd_dir    <= '0;
            r_cmd_end_cs <= 1'b0;
            r_cmd_hint   <= 1'b0;
            r_okuma      <= 1'b0;
        end else begin
            case (r_durum)
                c_ST_BOSTA: begin
                    if (w_basla) begin
                        r_cmd_valid  <= 1'b1;
                        r_cmd_data   <= w_tx_bas.data;
                        r_cmd_dir    <= w_tx_bas.dir;
                        r_cmd_end_cs <= w_tx_bas.end_cs;
                        r_cmd_hint   <= w_tx_bas.hint;
                        r_okuma      <= rx_rezerve(w_tx_bas.dir);
                        r_durum      <= c_ST_GONDER;
                    end
                end
                c_ST_GONDER: begin
                    if (spi_cmd_ready_i) begin
                        r_cmd_valid <= 1'b0;
                        r_durum     <= c_ST_BASLADI;
                    end
                end
                // The SPI unit may still show the pre-accept ready here, so skip a cycle.
                c_ST_BASLADI: begin
                    r_durum <= c_ST_BEKLE;
                end
                c_ST_BEKLE: begin
                    if (r_okuma) begin
                        if (spi_recv_valid_i) begin
                            r_okuma <= 1'b0;
                            r_durum <= c_ST_BOSTA;
                        end
                    end else if (spi_cmd_ready_i) begin
                        r_durum <= c_ST_BOSTA;
                    end
                end
                default: begin
                    r_durum <= c_ST_BOSTA;
                end
            endcase
        end
    end

    assign spi_cmd_valid_o     = r_cmd_valid;
    assign spi_cmd_data_o      = r_cmd_data;
    assign spi_cmd_dir_o       = r_cmd_dir;
    assign spi_cmd_end_cs_o    = r_cmd_end_cs;
    assign spi_cmd_hint_o      = r_cmd_hint;
    assign spi_cmd_cpol_o      = cfg_cpol_i;
    assign spi_cmd_cpha_o      = cfg_cpha_i;
    assign spi_cmd_msb_first_o = cfg_msb_first_i;
    assign spi_cmd_sck_div_o   = cfg_sck_div_i;

    assign busy_o = ~w_tx_bos | (r_durum != c_ST_BOSTA);

endmodule

`default_nettype wire
